// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side bundle for the PS/2 receiver: FIFO head entry, handshake,
// occupancy and error pulses. The receiver uses the master view and the
// keypad/calculator logic uses the slave view.
interface ps2_rx_fifo_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  logic [7:0]       code_o;
  logic             ext_o;
  logic             brk_o;
  logic             valid_o;
  logic             ready_i;
  logic [LVL_W-1:0] level_o;
  logic [2:0]       err_o;

  modport master (
    output code_o, ext_o, brk_o, valid_o, level_o, err_o,
    input  ready_i
  );

  modport slave (
    input  code_o, ext_o, brk_o, valid_o, level_o, err_o,
    output ready_i
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver with scancode FIFO.
// Synchronises the PS/2 lines, deserialises 11-bit frames, checks parity and
// stop bit, aborts stalled frames, folds E0/F0 prefixes into ext/brk flags and
// queues {ext, brk, code} entries behind a first-word-fall-through FIFO.
// Optional macro PS2_RX_TYPEMATIC_FILTER_EN drops auto-repeated make codes.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1000,
  parameter int PARITY_ODD  = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ps2_clk_i,
  input  logic          ps2_data_i,
  ps2_rx_fifo_if.master bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   prev_clk_q, prev_clk_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   ext_pend_q, ext_pend_d;
  logic                   brk_pend_q, brk_pend_d;
  logic [2:0]             err_q, err_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       count_q, count_d;
  logic [9:0]             mem_q [FIFO_DEPTH];
  logic [9:0]             mem_d [FIFO_DEPTH];

  logic ps2_clk_s, ps2_data_s, strobe;
  logic cand, push_req, rep_drop, par_err, frm_err;
  logic valid, pop, do_push, overflow;
  logic [9:0] head;

  // Shift the raw PS/2 lines through the synchronisers and detect falling edges
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
    ps2_clk_s   = clk_sync_q[SYNC_STAGES-1];
    ps2_data_s  = data_sync_q[SYNC_STAGES-1];
    prev_clk_d  = ps2_clk_s;
    strobe      = !ps2_clk_s && prev_clk_q;
  end

  // Frame FSM: deserialise, check the frame, abort on stall, track prefixes
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tmo_d      = '0;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    cand       = 1'b0;
    par_err    = 1'b0;
    frm_err    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (strobe && !ps2_data_s) begin
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (strobe) begin
          shift_d   = {ps2_data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (strobe) begin
          par_d   = ps2_data_s;
          state_d = STOP;
        end
      end
      STOP: begin
        if (strobe) begin
          state_d = IDLE;
          if (!ps2_data_s) begin
            frm_err = 1'b1;
          end else if (par_q != ((^shift_q) ^ (PARITY_ODD != 0))) begin
            par_err = 1'b1;
          end else if (shift_q == 8'hE0) begin
            ext_pend_d = 1'b1;
          end else if (shift_q == 8'hF0) begin
            brk_pend_d = 1'b1;
          end else begin
            cand       = 1'b1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && !strobe) begin
      if (tmo_q == TMO_LAST) begin
        state_d = IDLE;
        frm_err = 1'b1;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
    if (par_err || frm_err) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end
  end

  assign push_req = cand && !rep_drop;

`ifdef PS2_RX_TYPEMATIC_FILTER_EN
  logic       last_vld_q, last_vld_d;
  logic [8:0] last_q, last_d;

  assign rep_drop = !brk_pend_q && last_vld_q && (last_q == {ext_pend_q, shift_q});

  // Remember the last pushed make code; forget it on its break or on any error
  always_comb begin
    last_vld_d = last_vld_q;
    last_d     = last_q;
    if (par_err || frm_err || overflow) begin
      last_vld_d = 1'b0;
    end else if (push_req) begin
      if (brk_pend_q) begin
        if (last_vld_q && last_q == {ext_pend_q, shift_q}) last_vld_d = 1'b0;
      end else begin
        last_vld_d = 1'b1;
        last_d     = {ext_pend_q, shift_q};
      end
    end
  end

  // Repeat-filter state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_vld_q <= 1'b0;
      last_q     <= '0;
    end else begin
      last_vld_q <= last_vld_d;
      last_q     <= last_d;
    end
  end
`else
  assign rep_drop = 1'b0;
`endif

  // FIFO bookkeeping: pop on handshake, push unless full without a pop
  always_comb begin
    valid    = (count_q != '0);
    pop      = valid && bus.ready_i;
    do_push  = push_req && ((count_q != LVL_FULL) || pop);
    overflow = push_req && (count_q == LVL_FULL) && !pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = {ext_pend_q, brk_pend_q, shift_q};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !pop) count_d = count_q + LVL_W'(1);
    else if (pop && !do_push) count_d = count_q - LVL_W'(1);
    err_d = {overflow, frm_err, par_err};
    head  = mem_q[rd_ptr_q];
  end

  // State, synchroniser and FIFO control registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      prev_clk_q  <= 1'b1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      err_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      prev_clk_q  <= prev_clk_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      err_q       <= err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage; contents are only visible while the entry is valid
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign bus.valid_o = valid;
  assign bus.code_o  = valid ? head[7:0] : 8'h00;
  assign bus.brk_o   = valid && head[8];
  assign bus.ext_o   = valid && head[9];
  assign bus.level_o = count_q;
  assign bus.err_o   = err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed testbench for ps2_rx_fifo: sends hand-built PS/2 frames and checks
// popped entries, error pulses and FIFO occupancy against expected values.
module tb_ps2_rx_fifo;

  localparam int TMO = 1000;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic ps2_clk_i = 1'b1;
  logic ps2_data_i = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  int got_base = 0;
  int par_cnt = 0, frm_cnt = 0, ovf_cnt = 0;
  int par_base = 0, frm_base = 0, ovf_base = 0;

  ps2_rx_fifo_if #(.FIFO_DEPTH(4)) bus ();

  ps2_rx_fifo #(
    .FIFO_DEPTH(4), .SYNC_STAGES(2), .TIMEOUT_CYC(TMO), .PARITY_ODD(0)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ps2_clk_i(ps2_clk_i),
    .ps2_data_i(ps2_data_i), .bus(bus)
  );

  always #5 clk_i = ~clk_i;

  // Record popped entries and error pulses away from the active edge
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (bus.valid_o && bus.ready_i) got_q.push_back({bus.ext_o, bus.brk_o, bus.code_o});
      if (bus.err_o[0]) par_cnt++;
      if (bus.err_o[1]) frm_cnt++;
      if (bus.err_o[2]) ovf_cnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  function automatic logic [10:0] makeFrame(input logic [7:0] b, input bit badPar, input bit stopBit);
    return {stopBit, (^b) ^ badPar, b, 1'b0};
  endfunction

  // Send the first nbits of a frame; optionally pulse ready_i in the pop cycle of the stop bit
  task automatic applyStimulus(input logic [10:0] frame, input int nbits, input bit popOnStop);
    for (int i = 0; i < nbits; i++) begin
      ps2_data_i = frame[i];
      tick(2);
      ps2_clk_i = 1'b0;
      if (popOnStop && i == 10) begin
        tick(2);
        bus.ready_i = 1'b1;
        tick(1);
        bus.ready_i = 1'b0;
        tick(2);
      end else begin
        tick(5);
      end
      ps2_clk_i = 1'b1;
      tick(3);
    end
    ps2_data_i = 1'b1;
    tick(3);
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(makeFrame(b, 1'b0, 1'b1), 11, 1'b0);
  endtask

  function automatic logic [9:0] gotAt(input int i);
    if (i < got_q.size()) return got_q[i];
    return 10'h3FF;
  endfunction

  task automatic checkEntries(input string tag);
    tick(10);
    checkOutput({tag, "_n"}, got_q.size() - got_base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      checkOutput($sformatf("%s_e%0d", tag, i), {22'd0, gotAt(got_base + i)}, {22'd0, exp_q[i]});
    exp_q.delete();
    got_base = got_q.size();
  endtask

  task automatic checkErr(input string tag, input int ep, input int ef, input int eo);
    checkOutput({tag, "_par"}, par_cnt - par_base, ep);
    checkOutput({tag, "_frm"}, frm_cnt - frm_base, ef);
    checkOutput({tag, "_ovf"}, ovf_cnt - ovf_base, eo);
    par_base = par_cnt;
    frm_base = frm_cnt;
    ovf_base = ovf_cnt;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.ready_i = 1'b0;
    tick(5);
    checkOutput("rst_valid", bus.valid_o, 0);
    checkOutput("rst_level", bus.level_o, 0);
    checkOutput("rst_err", bus.err_o, 0);
    checkOutput("rst_head", {bus.ext_o, bus.brk_o, bus.code_o}, 0);
    rst_i = 1'b0;
    tick(5);

    $display("[TB] plain make codes");
    bus.ready_i = 1'b1;
    sendByte(8'h46); sendByte(8'h16); sendByte(8'h1E);
    exp_q = '{10'h046, 10'h016, 10'h01E};
    checkEntries("make");
    checkErr("make", 0, 0, 0);

    $display("[TB] prefixes");
    sendByte(8'hF0); sendByte(8'h16);
    sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h75);
    exp_q = '{10'h116, 10'h375};
    checkEntries("pfx");
    checkErr("pfx", 0, 0, 0);

    $display("[TB] parity error");
    applyStimulus(makeFrame(8'h26, 1'b1, 1'b1), 11, 1'b0);
    checkEntries("par");
    checkErr("par", 1, 0, 0);
    sendByte(8'h55);
    exp_q = '{10'h055};
    checkEntries("par_next");

    $display("[TB] framing error and timeout");
    applyStimulus(makeFrame(8'h76, 1'b0, 1'b0), 11, 1'b0);
    checkEntries("stop");
    checkErr("stop", 0, 1, 0);
    applyStimulus(makeFrame(8'h7B, 1'b0, 1'b1), 5, 1'b0);
    tick(TMO + 50);
    checkEntries("tmo");
    checkErr("tmo", 0, 1, 0);
    sendByte(8'h7B);
    exp_q = '{10'h07B};
    checkEntries("tmo_next");

    $display("[TB] reset mid-frame");
    sendByte(8'hE0);
    applyStimulus(makeFrame(8'h33, 1'b0, 1'b1), 5, 1'b0);
    rst_i = 1'b1;
    tick(3);
    rst_i = 1'b0;
    tick(5);
    sendByte(8'h2A);
    exp_q = '{10'h02A};
    checkEntries("midrst");
    checkErr("midrst", 0, 0, 0);

    $display("[TB] overflow");
    bus.ready_i = 1'b0;
    sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h44);
    tick(5);
    checkOutput("lvl4", bus.level_o, 4);
    checkOutput("head_full", {bus.ext_o, bus.brk_o, bus.code_o}, 10'h011);
    sendByte(8'h55);
    tick(5);
    checkOutput("lvl_ovf", bus.level_o, 4);
    checkErr("ovf", 0, 0, 1);
    applyStimulus(makeFrame(8'h66, 1'b0, 1'b1), 11, 1'b1);
    tick(5);
    checkOutput("lvl_pushpop", bus.level_o, 4);
    checkErr("pushpop", 0, 0, 0);
    bus.ready_i = 1'b1;
    exp_q = '{10'h011, 10'h022, 10'h033, 10'h044, 10'h066};
    checkEntries("drain");
    checkOutput("lvl_empty", bus.level_o, 0);

    $display("[TB] repeated make codes");
    sendByte(8'h46); sendByte(8'h46); sendByte(8'h46);
    sendByte(8'hF0); sendByte(8'h46); sendByte(8'h46);
`ifdef PS2_RX_TYPEMATIC_FILTER_EN
    exp_q = '{10'h046, 10'h146, 10'h046};
`else
    exp_q = '{10'h046, 10'h046, 10'h046, 10'h146, 10'h046};
`endif
    checkEntries("rep");
    checkErr("rep", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
